// File: rtl/vga_pkg.sv
// Shared colour/level definitions for the VGA pixel output path.
// Imported by the output stage.
package vga_pkg;

  localparam int RGB_W    = 12;
  localparam int NIB_W    = 4;
  localparam int R_LSB    = 0;
  localparam int G_LSB    = 4;
  localparam int B_LSB    = 8;
  localparam int LVL_W    = 4;
  localparam int BUNDLE_W = RGB_W + 3;

  localparam logic [RGB_W-1:0] BLACK = 12'h000;
  localparam logic [RGB_W-1:0] WHITE = 12'hFFF;

  typedef enum logic [1:0] {
    PEND_ZERO = 2'b00,
    PEND_UP   = 2'b01,
    PEND_DN   = 2'b11
  } pend_e;

  typedef struct packed {
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic [RGB_W-1:0] rgb;
  } pix_t;

  function automatic logic [NIB_W-1:0] sat_add_nib(
    input logic [NIB_W-1:0] nib,
    input logic [LVL_W-1:0] lvl
  );
    logic signed [5:0] sum;
    sum = $signed({2'b00, nib}) + $signed({{2{lvl[LVL_W-1]}}, lvl});
    if (sum < 6'sd0)
      return '0;
    else if (sum > 6'sd15)
      return '1;
    else
      return sum[NIB_W-1:0];
  endfunction

endpackage

// File: rtl/pix_delay_line.sv
// Enable-gated shift register; every stage holds unless en is high.
// Reset value is a parameter so sync bits can idle high.
module pix_delay_line #(
  parameter int               WIDTH   = 15,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      stage_d[i] = stage_q[i];
    if (en) begin
      stage_d[0] = d;
      for (int i = 1; i < DEPTH; i++)
        stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        stage_q[i] <= RST_VAL;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        stage_q[i] <= stage_d[i];
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_out_stage.sv
// VGA pixel output stage: sync realignment, blanking and a
// brightness offset committed only at frame boundaries.
module vga_out_stage
  import vga_pkg::*;
#(
  parameter int PIPE_DEPTH = 2,
  parameter int LVL_MAX    = 7
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [RGB_W-1:0]  rgb_in,
  input  logic              bright_up,
  input  logic              bright_down,
  output logic              hsync,
  output logic              vsync,
  output logic [RGB_W-1:0]  rgb,
  output logic [LVL_W-1:0]  level,
  output logic              frame_start
);

  localparam logic signed [LVL_W:0] LVL_HI =
    (LVL_W+1)'(LVL_MAX);
  localparam logic signed [LVL_W:0] LVL_LO =
    (LVL_W+1)'(-(LVL_MAX + 1));
  localparam logic [BUNDLE_W-1:0] DLY_RST =
    {1'b1, 1'b1, 1'b0, BLACK};

  pix_t in_pix;
  pix_t dly_pix;

  assign in_pix = {hsync_in, vsync_in, video_on, rgb_in};

  pix_delay_line #(
    .WIDTH   (BUNDLE_W),
    .DEPTH   (PIPE_DEPTH),
    .RST_VAL (DLY_RST)
  ) u_dly (
    .clk (clk_100MHz),
    .rst (reset),
    .en  (p_tick),
    .d   (in_pix),
    .q   (dly_pix)
  );

  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             fs_q, fs_d;
  pend_e            pend_q, pend_d;
  logic             vs_prev_q, vs_prev_d;
  logic             up_hist_q, up_hist_d;
  logic             dn_hist_q, dn_hist_d;

  logic              up_edge;
  logic              dn_edge;
  logic              boundary;
  pend_e             pend_base;
  logic signed [LVL_W:0] lvl_sum;

  always_comb begin
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    rgb_d     = rgb_q;
    level_d   = level_q;
    vs_prev_d = vs_prev_q;
    up_hist_d = bright_up;
    dn_hist_d = bright_down;

    up_edge  = bright_up & ~up_hist_q;
    dn_edge  = bright_down & ~dn_hist_q;
    boundary = p_tick & vs_prev_q & ~vsync_in;
    fs_d     = boundary;

    if (p_tick) begin
      vs_prev_d = vsync_in;
      hsync_d   = dly_pix.hsync;
      vsync_d   = dly_pix.vsync;
      rgb_d     = BLACK;
      if (dly_pix.video_on) begin
        rgb_d[R_LSB +: NIB_W] =
          sat_add_nib(dly_pix.rgb[R_LSB +: NIB_W], level_q);
        rgb_d[G_LSB +: NIB_W] =
          sat_add_nib(dly_pix.rgb[G_LSB +: NIB_W], level_q);
        rgb_d[B_LSB +: NIB_W] =
          sat_add_nib(dly_pix.rgb[B_LSB +: NIB_W], level_q);
      end
    end

    // pend_q encoding doubles as its 2-bit two's complement value
    lvl_sum = $signed({level_q[LVL_W-1], level_q})
            + $signed({{(LVL_W-1){pend_q[1]}}, pend_q});
    if (boundary) begin
      if (lvl_sum > LVL_HI)
        level_d = LVL_HI[LVL_W-1:0];
      else if (lvl_sum < LVL_LO)
        level_d = LVL_LO[LVL_W-1:0];
      else
        level_d = lvl_sum[LVL_W-1:0];
    end

    // a same-clk button edge lands in the freshly cleared value
    pend_base = boundary ? PEND_ZERO : pend_q;
    unique case (1'b1)
      up_edge && !dn_edge:
        pend_d = (pend_base == PEND_DN) ? PEND_ZERO : PEND_UP;
      dn_edge && !up_edge:
        pend_d = (pend_base == PEND_UP) ? PEND_ZERO : PEND_DN;
      default:
        pend_d = pend_base;
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      rgb_q     <= BLACK;
      level_q   <= '0;
      fs_q      <= 1'b0;
      pend_q    <= PEND_ZERO;
      vs_prev_q <= 1'b1;
      up_hist_q <= 1'b0;
      dn_hist_q <= 1'b0;
    end else begin
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      rgb_q     <= rgb_d;
      level_q   <= level_d;
      fs_q      <= fs_d;
      pend_q    <= pend_d;
      vs_prev_q <= vs_prev_d;
      up_hist_q <= up_hist_d;
      dn_hist_q <= dn_hist_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb         = rgb_q;
  assign level       = level_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_out_stage.sv
// Self-checking bench for vga_out_stage: directed scenarios plus
// random stimulus against a queue-based reference model.
module tb_vga_out_stage;

  localparam int D = 2;

  logic        clk_100MHz = 1'b0;
  logic        reset;
  logic        p_tick;
  logic        video_on;
  logic        hsync_in;
  logic        vsync_in;
  logic [11:0] rgb_in;
  logic        bright_up;
  logic        bright_down;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;
  logic [3:0]  level;
  logic        frame_start;

  always #5 clk_100MHz = ~clk_100MHz;

  vga_out_stage #(
    .PIPE_DEPTH (D),
    .LVL_MAX    (7)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .reset       (reset),
    .p_tick      (p_tick),
    .video_on    (video_on),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .rgb_in      (rgb_in),
    .bright_up   (bright_up),
    .bright_down (bright_down),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb),
    .level       (level),
    .frame_start (frame_start)
  );

  int vectors = 0;
  int errors  = 0;
  int phase   = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    bit        hs;
    bit        vs;
    bit        von;
    bit [11:0] c;
  } ent_t;

  ent_t        line_q[$];
  int          m_lvl;
  int          m_pend;
  bit          m_up, m_dn, m_vs;
  bit          e_hs, e_vs, e_fs;
  logic [11:0] e_rgb;

  function automatic int clampi(input int v, input int lo,
                                input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [11:0] adjust(input logic [11:0] c,
                                         input bit von,
                                         input int l);
    logic [11:0] r;
    r = 12'h000;
    if (von) begin
      for (int ch = 0; ch < 3; ch++)
        r[4*ch +: 4] = 4'(clampi(int'(c[4*ch +: 4]) + l, 0, 15));
    end
    return r;
  endfunction

  task automatic model_reset();
    ent_t idle;
    idle = {1'b1, 1'b1, 1'b0, 12'h000};
    m_lvl = 0; m_pend = 0;
    m_up = 0; m_dn = 0; m_vs = 1;
    e_hs = 1; e_vs = 1; e_fs = 0; e_rgb = 12'h000;
    line_q.delete();
    for (int i = 0; i < D; i++) line_q.push_back(idle);
  endtask

  task automatic model_clk();
    bit   bnd, ue, de;
    ent_t o, n;
    if (reset) begin
      model_reset();
      return;
    end
    bnd = p_tick && m_vs && !vsync_in;
    ue  = bright_up && !m_up;
    de  = bright_down && !m_dn;
    if (p_tick) begin
      o = line_q.pop_front();
      e_hs  = o.hs;
      e_vs  = o.vs;
      e_rgb = adjust(o.c, o.von, m_lvl);
      n = {hsync_in, vsync_in, video_on, rgb_in};
      line_q.push_back(n);
      m_vs = vsync_in;
    end
    if (bnd) begin
      m_lvl  = clampi(m_lvl + m_pend, -8, 7);
      m_pend = 0;
    end
    m_pend = clampi(m_pend + int'(ue) - int'(de), -1, 1);
    e_fs = bnd;
    m_up = bright_up;
    m_dn = bright_down;
  endtask

  task automatic cyc();
    p_tick = (phase == 0);
    @(posedge clk_100MHz);
    model_clk();
    #1;
    check("hsync", {31'd0, hsync}, {31'd0, e_hs});
    check("vsync", {31'd0, vsync}, {31'd0, e_vs});
    check("rgb", {20'd0, rgb}, {20'd0, e_rgb});
    check("level", {28'd0, level}, {28'd0, 4'(m_lvl)});
    check("frame_start", {31'd0, frame_start}, {31'd0, e_fs});
    phase = (phase + 1) % 4;
  endtask

  task automatic pix();
    repeat (4) cyc();
  endtask

  task automatic align();
    while (phase != 0) cyc();
  endtask

  task automatic frame();
    align();
    vsync_in = 1'b0;
    cyc();
    check("fs_rise", {31'd0, frame_start}, 32'd1);
    cyc();
    check("fs_width", {31'd0, frame_start}, 32'd0);
    repeat (2) cyc();
    vsync_in = 1'b1;
    pix();
  endtask

  task automatic pulse_up();
    bright_up = 1'b1; cyc();
    bright_up = 1'b0; cyc();
  endtask

  task automatic pulse_dn();
    bright_down = 1'b1; cyc();
    bright_down = 1'b0; cyc();
  endtask

  task automatic show(input logic [11:0] c, input bit von);
    align();
    rgb_in = c;
    video_on = von;
    repeat (D + 1) pix();
  endtask

  initial begin
    reset = 1'b1; p_tick = 1'b0;
    video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    rgb_in = 12'h000; bright_up = 1'b0; bright_down = 1'b0;
    model_reset();

    repeat (3) cyc();
    check("rst_hsync", {31'd0, hsync}, 32'd1);
    check("rst_rgb", {20'd0, rgb}, 32'd0);
    check("rst_level", {28'd0, level}, 32'd0);
    reset = 1'b0;
    align();

    // alignment
    rgb_in = 12'h5FF; video_on = 1'b1; hsync_in = 1'b0;
    pix();
    hsync_in = 1'b1; rgb_in = 12'h000;
    pix();
    check("align_early", {31'd0, hsync}, 32'd1);
    pix();
    check("align_hs", {31'd0, hsync}, 32'd0);
    check("align_rgb", {20'd0, rgb}, 32'h5FF);
    pix();
    check("align_after", {31'd0, hsync}, 32'd1);

    // blanking
    show(12'hFFF, 1'b0);
    check("blank", {20'd0, rgb}, 32'h000);

    // deferred commit
    video_on = 1'b1;
    pulse_up();
    pix();
    check("defer_lvl", {28'd0, level}, 32'd0);
    show(12'h5FF, 1'b1);
    check("defer_rgb", {20'd0, rgb}, 32'h5FF);
    frame();
    check("commit_lvl", {28'd0, level}, 32'd1);
    show(12'h5FF, 1'b1);
    check("commit_rgb", {20'd0, rgb}, 32'h6FF);

    // saturation at the bottom
    repeat (10) begin
      pulse_dn();
      frame();
    end
    check("sat_lvl", {28'd0, level}, 32'h8);
    show(12'h00F, 1'b1);
    check("sat_rgb_a", {20'd0, rgb}, 32'h007);
    show(12'h5FF, 1'b1);
    check("sat_rgb_b", {20'd0, rgb}, 32'h077);

    // cancel, then held button
    bright_up = 1'b1; bright_down = 1'b1; cyc();
    bright_up = 1'b0; bright_down = 1'b0; cyc();
    frame();
    check("cancel_lvl", {28'd0, level}, 32'h8);
    bright_up = 1'b1;
    repeat (3) frame();
    bright_up = 1'b0; cyc();
    frame();
    check("held_lvl", {28'd0, level}, 32'h9);

    // reset mid-frame with level 3 and a pending step
    repeat (10) begin
      pulse_up();
      frame();
    end
    check("pre_rst_lvl", {28'd0, level}, 32'd3);
    pulse_up();
    show(12'h5FF, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("arst_hsync", {31'd0, hsync}, 32'd1);
    check("arst_vsync", {31'd0, vsync}, 32'd1);
    check("arst_rgb", {20'd0, rgb}, 32'h000);
    check("arst_level", {28'd0, level}, 32'd0);
    check("arst_fs", {31'd0, frame_start}, 32'd0);
    model_reset();
    repeat (2) cyc();
    reset = 1'b0;
    align();
    repeat (3) pix();
    check("post_rst_fs", {31'd0, frame_start}, 32'd0);
    frame();
    check("post_rst_lvl", {28'd0, level}, 32'd0);

    // random traffic
    repeat (4000) begin
      if (phase == 0) begin
        rgb_in   = 12'($urandom);
        video_on = 1'($urandom);
        hsync_in = ($urandom_range(0, 7) != 0);
        vsync_in = ($urandom_range(0, 4) != 0);
      end
      if ($urandom_range(0, 15) == 0) bright_up = ~bright_up;
      if ($urandom_range(0, 15) == 0) bright_down = ~bright_down;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
